ysyx_24100006_scoreboard: RTL and testbench
===========================================

// Module: ysyx_24100006_scoreboard
// PURPOSE
//  Parametrised scoreboard hazard unit; successor to the per-stage RAW compare unit.
//  Keeps a pending-write counter per architectural GPR instead of comparing against a fixed set of stages.
//  Works for any pipeline depth and for multi-cycle loads, LSU stalls and bus waits.
//  Sits beside ID: gates the ID->EX handshake (stall_id) and is credited by WB retirement.
// PARAMETERS
//  NR_REG   16  number of GPRs (RV32E); x0 is never tracked
//  REG_AW   4   GPR index width, $clog2(NR_REG)
//  CNT_W    2   pending counter width; max in-flight writes per reg = 2**CNT_W-1
//  PERF_W   32  stall-cycle perf counter width
// PORTS
//  clock          in   1       core clock
//  reset_n        in   1       async active-low reset
//  id_valid       in   1       ID holds a valid decoded instruction
//  ex_ready       in   1       EX can accept an instruction this cycle
//  id_rs1         in   REG_AW  source 1 index
//  id_rs1_ren     in   1       source 1 is read
//  id_rs2         in   REG_AW  source 2 index
//  id_rs2_ren     in   1       source 2 is read
//  id_rd          in   REG_AW  destination index
//  id_wen         in   1       instruction writes id_rd
//  wb_valid       in   1       WB retires an instruction this cycle (incl. killed ones)
//  wb_rd          in   REG_AW  retiring destination
//  wb_wen         in   1       retiring instruction held a scoreboard entry
//  stall_id       out  1       hold ID; comb
//  id_fire        out  1       id_valid & ex_ready & ~stall_id; comb
//  fwd_rs1_wb     out  1       rs1 taken from WB write data this cycle (0 if bypass off)
//  fwd_rs2_wb     out  1       as above for rs2
//  sb_busy        out  1       any counter nonzero (used by fence.i / CSR drain)
//  err_underflow  out  1       sticky: retire seen with counter already 0
//  stall_cycles   out  PERF_W  cycles where id_valid & stall_id
// BEHAVIOUR
//  - Reset (async, reset_n=0): all cnt[*]=0, err_underflow=0, stall_cycles=0.
//    Comb outputs then follow inputs: stall_id=0, fwd_*=0, sb_busy=0.
//  - inc[r] = id_fire & id_wen & id_rd==r & r!=0.
//  - dec[r] = wb_valid & wb_wen & wb_rd==r & r!=0.
//  - cnt[r] <= cnt[r] + inc[r] - dec[r]; visible next cycle; inc&dec same reg = no change.
//  - rawN = id_rsN_ren & id_rsN!=0 & cnt[id_rsN]!=0 & ~bypN.
//  - sat  = id_wen & id_rd!=0 & cnt[id_rd]==2**CNT_W-1 & ~dec[id_rd]; structural stall, counter never wraps.
//  - stall_id = id_valid & (raw1 | raw2 | sat); zero when id_valid=0.
//  - Load-use needs no special case: the load's rd stays pending until its WB retire, however many LSU wait cycles.
//  - Underflow: dec[r] with cnt[r]==0 leaves cnt[r] at 0 and sets err_underflow until reset.
//  - stall_cycles increments each cycle id_valid&stall_id; wraps at 2**PERF_W.
//  - Killed/flushed instructions that hold an entry retire via wb_valid with wb_wen=1 (no RF write).
//    Producers guarantee this, so the scoreboard needs no flush port.
//  - rd==rs of the issuing instruction: the source check uses cnt before this cycle's inc; no self-stall.
//  - All outputs except cnt-driven state are combinational from inputs and cnt; no added latency on the ID->EX path.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    bypN = dec[id_rsN] & cnt[id_rsN]==1 (last outstanding write retiring now).
//    Source issues this cycle and fwd_rsN_wb=1.
//  WB_BYPASS_EN undefined:
//    bypN=0, fwd_rs*_wb tied 0.
//    Consumer waits one extra cycle for RF write-then-read.
// TESTING
//  1 Reset: hold reset_n=0, drive id_valid=1 rs1=5 -> stall_id=0, sb_busy=0, stall_cycles=0; cnt all 0 after release.
//  2 RAW: issue wen rd=3; next cycle rs1=3 ren -> stall_id=1.
//    Retire wb_rd=3 -> bypass on: stall_id=0, fwd_rs1_wb=1 that cycle; bypass off: stall_id=0 one cycle later.
//  3 Load-use, 5-cycle LSU: load rd=7, dependent rs2=7 -> stall_id=1 for all wait cycles, stall_cycles counts them.
//    Clears on WB of rd=7.
//  4 WAW/saturation (CNT_W=2): issue 3 writes to rd=4 -> 4th write stalls (sat).
//    Same cycle as a retire of rd=4 -> issues, cnt stays 3.
//  5 x0 and simultaneous: issue rd=0 -> cnt untouched; rs1=0 never stalls.
//    Issue rd=2 while retiring rd=2 with cnt=1 -> cnt stays 1.
//  6 Underflow + async reset: retire rd=9 with cnt=0 -> err_underflow=1 sticky.
//    Assert reset_n mid-stall -> all state 0 immediately, without a clock edge.

Source files
------------

// File: rtl/ysyx_24100006_scoreboard.sv
// rtl/ysyx_24100006_scoreboard.sv - per-GPR pending-write scoreboard hazard unit (optional WB bypass: WB_BYPASS_EN)
module ysyx_24100006_scoreboard #(
   parameter int NR_REG = 16,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 2,
   parameter int PERF_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic              ex_ready,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_ren,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_ren,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wen,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_wen,
   output logic              stall_id,
   output logic              id_fire,
   output logic              fwd_rs1_wb,
   output logic              fwd_rs2_wb,
   output logic              sb_busy,
   output logic              err_underflow,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0]  cnt [NR_REG];
   logic [NR_REG-1:0] inc;
   logic [NR_REG-1:0] dec;
   logic [NR_REG-1:0] nz;
   logic              byp1;
   logic              byp2;
   logic              raw1;
   logic              raw2;
   logic              sat;

   // retire strobes and nonzero flags; x0 is never tracked
   always_comb begin
      dec = '0;
      nz  = '0;
      for (int r = 1; r < NR_REG; r++) begin
         dec[r] = wb_valid & wb_wen & (wb_rd == REG_AW'(r));
         nz[r]  = (cnt[r] != '0);
      end
   end

   // issue strobes; kept apart from the retire strobes since they depend on id_fire
   always_comb begin
      inc = '0;
      for (int r = 1; r < NR_REG; r++) begin
         inc[r] = id_fire & id_wen & (id_rd == REG_AW'(r));
      end
   end

`ifdef WB_BYPASS_EN
   assign byp1 = dec[id_rs1] & (cnt[id_rs1] == CNT_W'(1));
   assign byp2 = dec[id_rs2] & (cnt[id_rs2] == CNT_W'(1));
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // sources read pre-issue counters, so rd==rs of the same instruction never self-stalls
   assign raw1 = id_rs1_ren & nz[id_rs1] & ~byp1;
   assign raw2 = id_rs2_ren & nz[id_rs2] & ~byp2;
   // a retire to the same rd this cycle frees a slot, so the counter cannot wrap
   assign sat  = id_wen & (id_rd != '0) & (cnt[id_rd] == CNT_MAX) & ~dec[id_rd];

   assign stall_id   = id_valid & (raw1 | raw2 | sat);
   assign id_fire    = id_valid & ex_ready & ~stall_id;
   assign fwd_rs1_wb = id_rs1_ren & byp1;
   assign fwd_rs2_wb = id_rs2_ren & byp2;
   assign sb_busy    = |nz;

   // pending counters: net of issue and retire, floored at zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NR_REG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NR_REG; r++) begin
            if (inc[r] & ~dec[r])
               cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec[r] & ~inc[r] & nz[r])
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   // sticky flag for a retire that found nothing pending
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         err_underflow <= 1'b0;
      else if (|(dec & ~nz))
         err_underflow <= 1'b1;
   end

   // perf counter of cycles spent holding a valid ID instruction
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cycles <= '0;
      else if (stall_id)
         stall_cycles <= stall_cycles + PERF_W'(1);
   end

endmodule

// File: tb/tb_ysyx_24100006_scoreboard.sv
// tb/tb_ysyx_24100006_scoreboard.sv - self-checking bench for the scoreboard hazard unit
module tb_ysyx_24100006_scoreboard;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int PMAX = 3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        id_valid, ex_ready, id_rs1_ren, id_rs2_ren, id_wen;
   logic [3:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        wb_valid, wb_wen;
   logic        stall_id, id_fire, fwd_rs1_wb, fwd_rs2_wb, sb_busy, err_underflow;
   logic [31:0] stall_cycles;

   ysyx_24100006_scoreboard dut (
      .clock(clock), .reset_n(reset_n),
      .id_valid(id_valid), .ex_ready(ex_ready),
      .id_rs1(id_rs1), .id_rs1_ren(id_rs1_ren),
      .id_rs2(id_rs2), .id_rs2_ren(id_rs2_ren),
      .id_rd(id_rd), .id_wen(id_wen),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
      .stall_id(stall_id), .id_fire(id_fire),
      .fwd_rs1_wb(fwd_rs1_wb), .fwd_rs2_wb(fwd_rs2_wb),
      .sb_busy(sb_busy), .err_underflow(err_underflow),
      .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   int          pend [16];
   bit          m_err;
   logic [31:0] m_stall;
   bit          e_stall, e_fire, e_fwd1, e_fwd2, e_busy;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) pend[i] = 0;
      m_err   = 1'b0;
      m_stall = '0;
   endtask

   function automatic int retiring_reg();
      if (wb_valid && wb_wen && wb_rd != 4'd0) return int'(wb_rd);
      return 0;
   endfunction

   function automatic bit last_retire(int rs);
      return BYP && rs != 0 && rs == retiring_reg() && pend[rs] == 1;
   endfunction

   function automatic bit needs_wait(int rs, bit ren);
      return ren && rs != 0 && pend[rs] > 0 && !last_retire(rs);
   endfunction

   task automatic predict();
      int d;
      bit full;
      d       = retiring_reg();
      full    = id_wen && id_rd != 4'd0 && pend[id_rd] == PMAX && d != int'(id_rd);
      e_stall = id_valid && (needs_wait(int'(id_rs1), id_rs1_ren) ||
                             needs_wait(int'(id_rs2), id_rs2_ren) || full);
      e_fire  = id_valid && ex_ready && !e_stall;
      e_fwd1  = id_rs1_ren && last_retire(int'(id_rs1));
      e_fwd2  = id_rs2_ren && last_retire(int'(id_rs2));
      e_busy  = 1'b0;
      for (int i = 1; i < 16; i++) if (pend[i] > 0) e_busy = 1'b1;
   endtask

   task automatic commit();
      int d;
      bit ufl;
      d   = retiring_reg();
      ufl = d != 0 && pend[d] == 0;
      if (ufl) m_err = 1'b1;
      if (d != 0 && !ufl) pend[d]--;
      if (e_fire && id_wen && id_rd != 4'd0) pend[id_rd]++;
      if (e_stall) m_stall = m_stall + 32'd1;
   endtask

   task automatic check_now(input string tag);
      predict();
      check({tag, ".stall"}, 32'(stall_id), 32'(e_stall));
      check({tag, ".fire"},  32'(id_fire), 32'(e_fire));
      check({tag, ".fwd1"},  32'(fwd_rs1_wb), 32'(e_fwd1));
      check({tag, ".fwd2"},  32'(fwd_rs2_wb), 32'(e_fwd2));
      check({tag, ".busy"},  32'(sb_busy), 32'(e_busy));
      check({tag, ".err"},   32'(err_underflow), 32'(m_err));
      check({tag, ".scyc"},  stall_cycles, m_stall);
   endtask

   task automatic tick(input string tag);
      #1;
      check_now(tag);
      @(posedge clock);
      commit();
      #1;
   endtask

   task automatic drive(input logic v, input logic rdy,
                        input logic [3:0] rs1, input logic r1,
                        input logic [3:0] rs2, input logic r2,
                        input logic [3:0] rd, input logic wen,
                        input logic wbv, input logic [3:0] wbrd, input logic wbwen);
      id_valid = v;  ex_ready = rdy;
      id_rs1 = rs1;  id_rs1_ren = r1;
      id_rs2 = rs2;  id_rs2_ren = r2;
      id_rd = rd;    id_wen = wen;
      wb_valid = wbv; wb_rd = wbrd; wb_wen = wbwen;
   endtask

   initial begin
      logic [31:0] snap;
      logic [3:0]  a, b, c, w;
      int          s, pick;

      // reset held with a valid reader of x5
      model_reset();
      reset_n = 1'b0;
      drive(1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #3;
      check("rst.stall", 32'(stall_id), 32'd0);
      check("rst.busy",  32'(sb_busy), 32'd0);
      check("rst.scyc",  stall_cycles, 32'd0);
      check_now("rst");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      tick("idle");

      // RAW on x3
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0);
      tick("raw.issue");
      drive(1, 1, 4'd3, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("raw.held", 32'(stall_id), 32'd1);
      tick("raw.wait");
      drive(1, 1, 4'd3, 1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 1);
      #1 check("raw.retire", 32'(stall_id), BYP ? 32'd0 : 32'd1);
      check("raw.fwd", 32'(fwd_rs1_wb), BYP ? 32'd1 : 32'd0);
      tick("raw.retire");
      drive(1, 1, 4'd3, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("raw.after", 32'(stall_id), 32'd0);
      tick("raw.after");

      // load-use with a 5-cycle LSU wait
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 4'd0, 0);
      tick("lu.issue");
      snap = m_stall;
      drive(1, 1, 4'd0, 0, 4'd7, 1, 4'd1, 1, 0, 4'd0, 0);
      for (int i = 0; i < 5; i++) begin
         #1 check("lu.held", 32'(stall_id), 32'd1);
         tick("lu.wait");
      end
      #1 check("lu.count", stall_cycles, snap + 32'd5);
      drive(1, 1, 4'd0, 0, 4'd7, 1, 4'd1, 1, 1, 4'd7, 1);
      tick("lu.retire");
      drive(1, 1, 4'd0, 0, 4'd7, 1, 4'd1, 1, 0, 4'd0, 0);
      tick("lu.after");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 4'd1, 1);
      tick("lu.drain");

      // WAW saturation on x4
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) tick("sat.fill");
      #1 check("sat.held", 32'(stall_id), 32'd1);
      tick("sat.full");
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 4'd4, 1);
      #1 check("sat.swap", 32'(id_fire), 32'd1);
      tick("sat.swap");
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 4'd0, 0);
      #1 check("sat.still3", 32'(stall_id), 32'd1);
      tick("sat.still3");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 4'd4, 1);
      for (int i = 0; i < 3; i++) tick("sat.drain");
      #1 check("sat.empty", 32'(sb_busy), 32'd0);

      // x0 and simultaneous issue/retire on x2
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 4'd0, 0);
      tick("x0.issue");
      drive(1, 1, 4'd0, 1, 4'd0, 1, 4'd0, 0, 0, 4'd0, 0);
      #1 check("x0.busy", 32'(sb_busy), 32'd0);
      check("x0.read", 32'(stall_id), 32'd0);
      tick("x0.read");
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 4'd0, 0);
      tick("sim.first");
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1, 4'd2, 1);
      tick("sim.both");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("sim.one", 32'(sb_busy), 32'd1);
      tick("sim.one");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 4'd2, 1);
      tick("sim.retire");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("sim.empty", 32'(sb_busy), 32'd0);

      // underflow, then async reset in the middle of a stall
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 4'd9, 1);
      tick("ufl.retire");
      drive(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("ufl.set", 32'(err_underflow), 32'd1);
      tick("ufl.sticky");
      drive(1, 1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0);
      tick("ar.issue");
      drive(1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
      #1 check("ar.held", 32'(stall_id), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      model_reset();
      check("ar.stall", 32'(stall_id), 32'd0);
      check("ar.busy",  32'(sb_busy), 32'd0);
      check("ar.err",   32'(err_underflow), 32'd0);
      check("ar.scyc",  stall_cycles, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // randomized traffic over x0..x7 against the model
      for (int i = 0; i < 400; i++) begin
         a = 4'($urandom_range(0, 7));
         b = 4'($urandom_range(0, 7));
         c = 4'($urandom_range(0, 7));
         w = 4'd0;
         pick = $urandom_range(0, 3);
         if (pick <= 1) begin
            s = $urandom_range(1, 15);
            for (int k = 0; k < 15; k++) begin
               if (w == 4'd0 && pend[((s + k - 1) % 15) + 1] > 0)
                  w = 4'(((s + k - 1) % 15) + 1);
            end
         end
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               a, 1'($urandom), b, 1'($urandom), c, 1'($urandom),
               (w != 4'd0) || pick == 2,
               (w != 4'd0) ? w : 4'($urandom_range(0, 15)),
               (w != 4'd0));
         tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
